// File: rtl/mult16appx_pkg.sv
// Shared definitions for the mult16appx approximate-multiplier datapath:
// default operand widths and the payload held in the decoder's first stage.
package mult16appx_pkg;

   localparam int DEF_WIDTH  = 18;
   localparam int DEF_POS_W  = 5;
   localparam int DEF_FRAC_W = 8;

   // Layout is fixed at the default widths; the encoder emits the same codes.
   typedef struct packed {
      logic [DEF_WIDTH-1:0]  onehot;
      logic [DEF_POS_W-1:0]  pos;
      logic [DEF_FRAC_W-1:0] frac;
      logic                  zero;
      logic                  err;
   } s1_payload_t;

endpackage

// File: rtl/pos_onehot_dec.sv
// Combinational position-code to one-hot decoder with range check.
// A zero operand suppresses both the one-hot bit and the error flag.
module pos_onehot_dec
   import mult16appx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int POS_W = DEF_POS_W
) (
   input  logic [POS_W-1:0] pos,
   input  logic             zero,
   output logic [WIDTH-1:0] onehot,
   output logic             err
);

   always_comb begin
      err    = !zero && (int'(pos) >= WIDTH);
      onehot = '0;
      // An out-of-range code matches no index, so onehot stays clear on err.
      for (int i = 0; i < WIDTH; i++) begin
         onehot[i] = !zero && (int'(pos) == i);
      end
   end

endmodule

// File: rtl/pos_decoder.sv
// Two-stage valid/ready inverse of the leading-one encoder: S1 decodes the
// one-hot position, S2 forms the Mitchell antilog value (1.frac << pos).
module pos_decoder
   import mult16appx_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int POS_W  = DEF_POS_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [POS_W-1:0]  in_pos,
   input  logic [FRAC_W-1:0] in_frac,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_onehot,
   output logic [WIDTH-1:0]  out_value,
   output logic              out_err
);

   localparam int WIDE_W = WIDTH + FRAC_W;

   logic              dec_err;
   logic [WIDTH-1:0]  dec_onehot;
   s1_payload_t       s1_d;
   s1_payload_t       s1_q;
   logic              s1_valid;
   logic              s1_load;
   logic              s2_valid;
   logic              s2_load;
   logic [WIDTH-1:0]  s2_onehot;
   logic [WIDTH-1:0]  s2_value;
   logic              s2_err;
   logic [WIDE_W-1:0] wide;
   logic [WIDTH-1:0]  value_d;

   pos_onehot_dec #(
      .WIDTH (WIDTH),
      .POS_W (POS_W)
   ) u_dec (
      .pos    (in_pos),
      .zero   (in_zero),
      .onehot (dec_onehot),
      .err    (dec_err)
   );

   // S2 frees when empty or draining; S1 may refill in the same cycle it empties.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   always_comb begin
      s1_d        = '0;
      s1_d.onehot = dec_onehot;
      s1_d.pos    = in_pos;
      s1_d.frac   = in_frac;
      s1_d.zero   = in_zero;
      s1_d.err    = dec_err;
   end

   // NOTE: state and payload registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
         end
      end
   end

   // Antilog: the wide shift keeps the mantissa intact for every legal pos,
   // then dropping FRAC_W low bits truncates the fraction.
   always_comb begin
      wide    = WIDE_W'({1'b1, s1_q.frac}) << s1_q.pos;
      value_d = (s1_q.zero || s1_q.err) ? '0 : WIDTH'(wide >> FRAC_W);
   end

   // NOTE: the output payload is reset as well as the valid, because the
   // outputs must read zero during reset and not just be flagged invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_onehot <= '0;
         s2_value  <= '0;
         s2_err    <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_onehot <= s1_q.onehot;
            s2_value  <= value_d;
            s2_err    <= s1_q.err;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_onehot = s2_onehot;
   assign out_value  = s2_value;
   assign out_err    = s2_err;

endmodule
